l2c_refill: RTL and testbench
=============================

# l2c_refill

Downstream consumer of the L2C miss handler's MNI-side request. Accepts one miss request at a time, stalls the handler while busy, and issues it to the network interface. For reads, it collects the returned response words and writes them into the L2 data array. It pulses a completion strobe that is tagged with the requesting L1 (data or instruction).

## Interface
- LINE_LOG2, 4, log2 of words per cache line (16 words = 64 B).
- Clk  in  1  clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- i_miss_valid  in  1  miss request valid; held high until accepted.
- i_miss_adr  in  32  request address; line-aligned for line requests, word-aligned otherwise.
- i_miss_flags  in  2  [1]=cacheable, [0]=uncached-override.
- i_miss_wen  in  1  request is a word store.
- i_miss_wdata  in  32  store data, sampled with the request.
- i_dl2_sel  in  1  1 = requester is DL1, 0 = IL1.
- o_miss_stall  out  1  back-pressure to the miss handler.
- o_req_valid  out  1  network request valid.
- o_req_adr  out  32  network request address.
- o_req_wen  out  1  network request is a write.
- o_req_line  out  1  1 = 16-word line read, 0 = single word.
- o_req_data  out  32  store data.
- i_req_ack  in  1  network accepted the request (one-cycle pulse).
- i_rsp_valid  in  1  response word valid.
- i_rsp_data  in  32  response word.
- o_fill_we  out  1  L2 data array write enable.
- o_fill_adr  out  32  byte address of the word being written.
- o_fill_data  out  32  word to write.
- o_fill_dc  out  1  latched i_dl2_sel of the current transaction.
- o_fill_done  out  1  one-cycle completion pulse.

## Operation
**Request qualification**
- A request is a line request when i_miss_flags[1] & ~i_miss_flags[0], and a word request otherwise.
- Writes are always word requests; o_req_line = 0 whenever wen = 1.

**States (one-hot): Idle, Req, Fill, Done.**
- **Idle**
  - o_miss_stall = 0.
  - If i_miss_valid = 1, the request is accepted. Latch adr, flags, wen, wdata and dl2_sel, clear the word counter, and go to Req.
- **Req**
  - o_req_valid = 1, with o_req_* driven from the latched values.
  - Stay in Req until i_req_ack.
  - On ack, go to Done if wen = 1, otherwise go to Fill.
- **Fill**
  - Each i_rsp_valid registers one array write: o_fill_adr = {adr[31:6], cnt, 2'b0} for a line request, or adr for a word request. o_fill_data = i_rsp_data.
  - The counter (LINE_LOG2 bits) increments per word.
  - The last word is cnt = 15 for a line request, or the first word for a word request. After the last word, go to Done.
- **Done**
  - o_fill_done = 1 for exactly one cycle, then go to Idle.
- Any unused state encoding returns to Idle.

**Stall and ignored inputs**
- o_miss_stall = 1 in Req, Fill and Done. It is a function of state only.
- i_rsp_valid outside Fill is ignored: no write is issued and the counter does not change.
- i_req_ack outside Req is ignored.
- i_miss_valid while not in Idle is ignored; it stays pending under stall.

**Reset**
- Reset mid-transaction abandons it: state goes to Idle, the counter clears, and no done pulse is issued.
- Partially written lines are not invalidated by this block.

## Timing
**Reset values**
- Registered outputs after Reset: o_fill_we, o_fill_done, o_req_valid = 0; o_fill_dc = 0; o_fill_adr = 0; o_fill_data = 0.
- o_miss_stall = 0 in Idle.
- o_req_adr, o_req_wen, o_req_line and o_req_data are don't-care while o_req_valid = 0.

**Acceptance and request**
- Acceptance happens in cycle T, when Idle and i_miss_valid = 1.
- o_req_valid rises at T+1; o_miss_stall rises at T+1.
- The miss handler samples a stall of 0 in cycle T, which matches its own one-cycle accept semantics.
- With ack in cycle A: a write has o_fill_done at A+1 and Idle at A+2. A read is in Fill at A+1.
- i_rsp_valid may arrive from A+1 onward, with arbitrary gaps between words.

**Fill writes**
- A response in cycle R produces o_fill_we at R+1; the write is registered with one-cycle latency.
- o_fill_done is asserted in the same cycle as the final o_fill_we.
- Back-to-back responses produce back-to-back writes.
- Minimum line-read occupancy from accept to Idle is 19 cycles: Req 1, 16 responses, Done.

**Back-to-back requests**
- A new request can be accepted in the cycle after Done, the first Idle cycle.

## Test plan
- **Line read:** req adr=0x0000_1240, flags=2'b10, wen=0, ack after 3 cycles, 16 back-to-back rsp words 0xA0..0xAF.
  - Expect 16 writes at 0x1240..0x127C, data matching in order.
  - Expect o_fill_done on the 16th write; o_fill_dc = i_dl2_sel.
- **Uncached word read:** adr=0x0000_3004, flags=2'b11.
  - Expect o_req_line = 0 and a single write to 0x3004.
  - Expect done with the first write.
- **Word store:** wen=1, wdata=0xDEADBEEF.
  - Expect o_req_wen = 1 and o_req_data = 0xDEADBEEF.
  - Expect no fill writes and o_fill_done at ack+1.
- **Gapped responses:** line read with one idle cycle between each rsp.
  - Expect the counter to advance only on valid words.
  - Expect exactly 16 writes, and a stray rsp injected after done is ignored.
- **Stall handshake:** i_miss_valid held high across two transactions.
  - Expect o_miss_stall = 1 from T+1 until the cycle after Done, and a second accept in the first Idle cycle.
- **Reset mid-fill:** assert Reset after 7 of 16 words.
  - Expect state Idle and all outputs 0 the next cycle, with no o_fill_done.
  - A subsequent line read completes normally.

Source files
------------

// File: rtl/l2c_refill.sv
// L2C refill engine: takes one miss request at a time, issues it to the network
// interface and writes returned read data into the L2 data array.
module l2c_refill #(
    parameter int LINE_LOG2 = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_miss_valid,
    input  logic [31:0] i_miss_adr,
    input  logic [1:0]  i_miss_flags,
    input  logic        i_miss_wen,
    input  logic [31:0] i_miss_wdata,
    input  logic        i_dl2_sel,
    output logic        o_miss_stall,
    output logic        o_req_valid,
    output logic [31:0] o_req_adr,
    output logic        o_req_wen,
    output logic        o_req_line,
    output logic [31:0] o_req_data,
    input  logic        i_req_ack,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    output logic        o_fill_we,
    output logic [31:0] o_fill_adr,
    output logic [31:0] o_fill_data,
    output logic        o_fill_dc,
    output logic        o_fill_done
);

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_REQ  = 4'b0010;
    localparam logic [3:0] S_FILL = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    logic [3:0]           r_state;
    logic [31:0]          r_adr;
    logic                 r_line;
    logic                 r_wen;
    logic [31:0]          r_wdata;
    logic                 r_dc;
    logic [LINE_LOG2-1:0] r_cnt;
    logic                 r_fill_we;
    logic [31:0]          r_fill_adr;
    logic [31:0]          r_fill_data;

    logic                 w_line_req;
    logic                 w_last;
    logic [31:0]          w_fill_adr;

    // Stores are always single-word, whatever the cacheability flags say.
    assign w_line_req = i_miss_flags[1] & ~i_miss_flags[0] & ~i_miss_wen;
    assign w_last     = r_line ? (r_cnt == {LINE_LOG2{1'b1}}) : 1'b1;
    assign w_fill_adr = r_line ? {r_adr[31:LINE_LOG2+2], r_cnt, 2'b00} : r_adr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_adr       <= '0;
            r_line      <= 1'b0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_dc        <= 1'b0;
            r_cnt       <= '0;
            r_fill_we   <= 1'b0;
            r_fill_adr  <= '0;
            r_fill_data <= '0;
        end else begin
            r_fill_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_miss_valid) begin
                        r_adr   <= i_miss_adr;
                        r_line  <= w_line_req;
                        r_wen   <= i_miss_wen;
                        r_wdata <= i_miss_wdata;
                        r_dc    <= i_dl2_sel;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_req_ack) begin
                        r_state <= r_wen ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_rsp_valid) begin
                        r_fill_we   <= 1'b1;
                        r_fill_adr  <= w_fill_adr;
                        r_fill_data <= i_rsp_data;
                        r_cnt       <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Done lands on the final write because the write is registered on the
    // same edge that moves the FSM into S_DONE.
    assign o_miss_stall = (r_state != S_IDLE);
    assign o_req_valid  = (r_state == S_REQ);
    assign o_fill_done  = (r_state == S_DONE);
    assign o_req_adr    = r_adr;
    assign o_req_wen    = r_wen;
    assign o_req_line   = r_line;
    assign o_req_data   = r_wdata;
    assign o_fill_we    = r_fill_we;
    assign o_fill_adr   = r_fill_adr;
    assign o_fill_data  = r_fill_data;
    assign o_fill_dc    = r_dc;

endmodule

// File: tb/tb_l2c_refill.sv
// Bench for l2c_refill: directed scenarios plus randomized transactions checked
// against an address/data model derived from the request fields.
module tb_l2c_refill;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_miss_valid;
    logic [31:0] i_miss_adr;
    logic [1:0]  i_miss_flags;
    logic        i_miss_wen;
    logic [31:0] i_miss_wdata;
    logic        i_dl2_sel;
    logic        o_miss_stall;
    logic        o_req_valid;
    logic [31:0] o_req_adr;
    logic        o_req_wen;
    logic        o_req_line;
    logic [31:0] o_req_data;
    logic        i_req_ack;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        o_fill_we;
    logic [31:0] o_fill_adr;
    logic [31:0] o_fill_data;
    logic        o_fill_dc;
    logic        o_fill_done;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clk = ~Clk;

    l2c_refill #(.LINE_LOG2(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_miss_valid (i_miss_valid),
        .i_miss_adr   (i_miss_adr),
        .i_miss_flags (i_miss_flags),
        .i_miss_wen   (i_miss_wen),
        .i_miss_wdata (i_miss_wdata),
        .i_dl2_sel    (i_dl2_sel),
        .o_miss_stall (o_miss_stall),
        .o_req_valid  (o_req_valid),
        .o_req_adr    (o_req_adr),
        .o_req_wen    (o_req_wen),
        .o_req_line   (o_req_line),
        .o_req_data   (o_req_data),
        .i_req_ack    (i_req_ack),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_data   (i_rsp_data),
        .o_fill_we    (o_fill_we),
        .o_fill_adr   (o_fill_adr),
        .o_fill_data  (o_fill_data),
        .o_fill_dc    (o_fill_dc),
        .o_fill_done  (o_fill_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Entered and left with the DUT idle, sampled 1 time unit after an edge.
    task automatic run_txn(input logic [31:0] adr, input logic [1:0] flags, input logic wen,
                           input logic [31:0] wdata, input logic dc, input int ack_dly,
                           input int gap_min, input int gap_max, input logic hold,
                           input logic [31:0] dbase, input logic rnd_data);
        logic        line;
        int          nw;
        int          g;
        logic [31:0] d;
        logic [31:0] exp_adr;
        line = (flags == 2'b10) && !wen;
        nw   = wen ? 0 : (line ? 16 : 1);

        i_miss_adr   = adr;
        i_miss_flags = flags;
        i_miss_wen   = wen;
        i_miss_wdata = wdata;
        i_dl2_sel    = dc;
        i_miss_valid = 1'b1;
        chk("idle_stall", 32'(o_miss_stall), 32'd0);
        step();
        i_miss_valid = hold;
        if (!hold) begin
            i_miss_adr = $urandom;
            i_dl2_sel  = ~dc;
            i_miss_wen = ~wen;
        end
        chk("req_valid", 32'(o_req_valid), 32'd1);
        chk("req_stall", 32'(o_miss_stall), 32'd1);
        chk("req_adr", o_req_adr, adr);
        chk("req_wen", 32'(o_req_wen), 32'(wen));
        chk("req_line", 32'(o_req_line), 32'(line));
        if (wen) chk("req_data", o_req_data, wdata);

        for (int i = 0; i < ack_dly; i++) begin
            i_rsp_valid = 1'($urandom);
            i_rsp_data  = $urandom;
            step();
            i_rsp_valid = 1'b0;
            chk("req_hold", 32'(o_req_valid), 32'd1);
            chk("req_nowe", 32'(o_fill_we), 32'd0);
        end
        i_req_ack = 1'b1;
        step();
        i_req_ack = 1'b0;
        chk("ack_exit", 32'(o_req_valid), 32'd0);

        if (wen) begin
            chk("st_done", 32'(o_fill_done), 32'd1);
            chk("st_nowe", 32'(o_fill_we), 32'd0);
        end else begin
            for (int k = 0; k < nw; k++) begin
                g = $urandom_range(gap_max, gap_min);
                for (int j = 0; j < g; j++) begin
                    i_req_ack = 1'($urandom);
                    step();
                    i_req_ack = 1'b0;
                    chk("gap_nowe", 32'(o_fill_we), 32'd0);
                    chk("gap_nodone", 32'(o_fill_done), 32'd0);
                end
                d = rnd_data ? $urandom : dbase + 32'(k);
                i_rsp_valid = 1'b1;
                i_rsp_data  = d;
                step();
                i_rsp_valid = 1'b0;
                exp_adr = line ? ({adr[31:6], 6'b0} + 32'(4 * k)) : adr;
                chk("fill_we", 32'(o_fill_we), 32'd1);
                chk("fill_adr", o_fill_adr, exp_adr);
                chk("fill_data", o_fill_data, d);
                chk("fill_dc", 32'(o_fill_dc), 32'(dc));
                chk("fill_done", 32'(o_fill_done), 32'(k == nw - 1));
            end
        end

        // Leaving Done: a stray response and a held miss request must be ignored.
        i_miss_valid = hold;
        i_rsp_valid  = 1'($urandom);
        i_rsp_data   = $urandom;
        step();
        i_rsp_valid = 1'b0;
        chk("end_nodone", 32'(o_fill_done), 32'd0);
        chk("end_stall", 32'(o_miss_stall), 32'd0);
        chk("end_noreq", 32'(o_req_valid), 32'd0);
        chk("end_nowe", 32'(o_fill_we), 32'd0);
    endtask

    initial begin
        logic [1:0]  fl;
        logic        wn;
        logic [31:0] a;
        logic        hd;

        Reset        = 1'b1;
        i_miss_valid = 1'b0;
        i_miss_adr   = '0;
        i_miss_flags = '0;
        i_miss_wen   = 1'b0;
        i_miss_wdata = '0;
        i_dl2_sel    = 1'b0;
        i_req_ack    = 1'b0;
        i_rsp_valid  = 1'b0;
        i_rsp_data   = '0;
        step();
        step();
        Reset = 1'b0;
        chk("rst_we", 32'(o_fill_we), 32'd0);
        chk("rst_done", 32'(o_fill_done), 32'd0);
        chk("rst_reqv", 32'(o_req_valid), 32'd0);
        chk("rst_dc", 32'(o_fill_dc), 32'd0);
        chk("rst_adr", o_fill_adr, 32'd0);
        chk("rst_data", o_fill_data, 32'd0);
        chk("rst_stall", 32'(o_miss_stall), 32'd0);

        run_txn(32'h0000_1240, 2'b10, 1'b0, 32'd0, 1'b1, 3, 0, 0, 1'b0, 32'hA0, 1'b0);
        run_txn(32'h0000_3004, 2'b11, 1'b0, 32'd0, 1'b0, 1, 0, 0, 1'b0, 32'h55, 1'b0);
        run_txn(32'h8000_0010, 2'b00, 1'b1, 32'hDEAD_BEEF, 1'b1, 2, 0, 0, 1'b0, 32'd0, 1'b0);
        run_txn(32'h0000_5500, 2'b10, 1'b0, 32'd0, 1'b0, 0, 1, 1, 1'b0, 32'd0, 1'b1);
        run_txn(32'h0001_0040, 2'b10, 1'b0, 32'd0, 1'b1, 1, 0, 1, 1'b1, 32'd0, 1'b1);
        run_txn(32'h0001_0040, 2'b10, 1'b0, 32'd0, 1'b1, 1, 0, 1, 1'b0, 32'd0, 1'b1);

        // Reset after 7 of 16 words of a line read.
        i_miss_adr   = 32'h0000_2000;
        i_miss_flags = 2'b10;
        i_miss_wen   = 1'b0;
        i_dl2_sel    = 1'b1;
        i_miss_valid = 1'b1;
        step();
        i_miss_valid = 1'b0;
        i_req_ack    = 1'b1;
        step();
        i_req_ack = 1'b0;
        for (int k = 0; k < 7; k++) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = 32'h100 + 32'(k);
            step();
        end
        chk("mid_we", 32'(o_fill_we), 32'd1);
        chk("mid_adr", o_fill_adr, 32'h0000_2018);
        Reset = 1'b1;
        step();
        Reset       = 1'b0;
        i_rsp_valid = 1'b0;
        chk("mrst_we", 32'(o_fill_we), 32'd0);
        chk("mrst_done", 32'(o_fill_done), 32'd0);
        chk("mrst_reqv", 32'(o_req_valid), 32'd0);
        chk("mrst_stall", 32'(o_miss_stall), 32'd0);
        chk("mrst_adr", o_fill_adr, 32'd0);
        chk("mrst_data", o_fill_data, 32'd0);
        chk("mrst_dc", 32'(o_fill_dc), 32'd0);
        for (int k = 0; k < 3; k++) begin
            i_rsp_valid = 1'b1;
            step();
            i_rsp_valid = 1'b0;
            chk("post_rst_nowe", 32'(o_fill_we), 32'd0);
            chk("post_rst_nodone", 32'(o_fill_done), 32'd0);
        end
        run_txn(32'h0000_2000, 2'b10, 1'b0, 32'd0, 1'b1, 0, 0, 0, 1'b0, 32'd0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            fl = 2'($urandom);
            wn = ($urandom_range(3, 0) == 0);
            a  = $urandom & 32'hFFFF_FFFC;
            if (fl == 2'b10 && !wn) a = a & 32'hFFFF_FFC0;
            hd = (t < 39) ? 1'($urandom) : 1'b0;
            run_txn(a, fl, wn, $urandom, 1'($urandom), int'($urandom_range(3, 0)),
                    0, 2, hd, 32'd0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
